r_response_memory: RTL and testbench

R_RESPONSE_MEMORY -- requirements
Module: r_response_memory

---
 rtl/r_response_memory.sv | 153 +++++++++++++++
 tb/tb_r_response_memory.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_response_memory.sv
// Per-uid read-response reorder store: one circular buffer of {data, resp, last} per uid slot.
// Beats are stored by uid and released in arrival order for the uid the consumer selects.
module r_response_memory #(
    parameter int ID_WIDTH        = 32,
    parameter int MAX_OUTSTANDING = 16,
    parameter int NUM_ROWS        = MAX_OUTSTANDING,
    parameter int NUM_COLS        = MAX_OUTSTANDING,
    parameter int MAX_LEN         = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int RESP_WIDTH      = 2
) (
    input  logic                                             clk,
    input  logic                                             rst,
    // store side (receiver)
    input  logic [ID_WIDTH-1:0]                              r_store_id,
    input  logic [DATA_WIDTH-1:0]                            r_store_data,
    input  logic [RESP_WIDTH-1:0]                            r_store_resp,
    input  logic                                             r_store_last,
    input  logic                                             r_store_valid,
    output logic                                             r_store_ready,
    // release side (sender)
    input  logic [ID_WIDTH-1:0]                              rm_release_uid,
    output logic [ID_WIDTH-1:0]                              r_release_id,
    output logic [DATA_WIDTH-1:0]                            r_release_data,
    output logic [RESP_WIDTH-1:0]                            r_release_resp,
    output logic                                             r_release_last,
    output logic                                             r_release_valid,
    input  logic                                             r_release_ready,
    output logic [NUM_ROWS*NUM_COLS*$clog2(MAX_LEN+1)-1:0]   slot_count,
    output logic                                             err_release_empty
);

    localparam int NUM_SLOTS = NUM_ROWS * NUM_COLS;
    localparam int ROW_W     = $clog2(NUM_ROWS);
    localparam int COL_W     = $clog2(NUM_COLS);
    localparam int IDX_W     = ROW_W + COL_W;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);
    localparam int PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W     = $clog2(MAX_LEN + 1);
    localparam int ADDR_W    = $clog2(NUM_SLOTS * MAX_LEN);
    localparam int ENTRY_W   = DATA_WIDTH + RESP_WIDTH + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_LEN);

    function automatic logic [SLOT_W-1:0] uid_slot(input logic [IDX_W-1:0] idx);
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        row = idx[IDX_W-1:COL_W];
        col = idx[COL_W-1:0];
        return SLOT_W'(int'(row) * NUM_COLS + int'(col));
    endfunction

    // Explicit compare so non-power-of-two depths wrap correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [SLOT_W-1:0]  st_slot;
    logic [SLOT_W-1:0]  rl_slot;
    logic [CNT_W-1:0]   cnt_all  [NUM_SLOTS];
    logic [PTR_W-1:0]   wptr_all [NUM_SLOTS];
    logic [PTR_W-1:0]   rptr_all [NUM_SLOTS];
    logic [ENTRY_W-1:0] mem      [NUM_SLOTS * MAX_LEN];
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;
    logic               st_fire;
    logic               rl_fire;
    logic               err_reg;

    assign st_slot = uid_slot(r_store_id[IDX_W-1:0]);
    assign rl_slot = uid_slot(rm_release_uid[IDX_W-1:0]);

    assign r_store_ready   = (cnt_all[st_slot] != FULL_COUNT);
    assign r_release_valid = (cnt_all[rl_slot] != '0);
    assign st_fire         = r_store_valid & r_store_ready;
    assign rl_fire         = r_release_ready & r_release_valid;

    assign wr_addr = ADDR_W'(int'(st_slot) * MAX_LEN + int'(wptr_all[st_slot]));
    assign rd_addr = ADDR_W'(int'(rl_slot) * MAX_LEN + int'(rptr_all[rl_slot]));

    // Release data must be visible in the same cycle, so the read is combinational.
    assign {r_release_data, r_release_resp, r_release_last} = mem[rd_addr];
    assign r_release_id      = rm_release_uid;
    assign err_release_empty = err_reg;

    always_ff @(posedge clk) begin
        if (st_fire) begin
            mem[wr_addr] <= {r_store_data, r_store_resp, r_store_last};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (r_release_ready && !r_release_valid) begin
            err_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic             st_hit;
            logic             rl_hit;
            logic [CNT_W-1:0] count_reg, count_next;
            logic [PTR_W-1:0] wptr_reg, wptr_next;
            logic [PTR_W-1:0] rptr_reg, rptr_next;

            assign st_hit = st_fire && (st_slot == SLOT_W'(gi));
            assign rl_hit = rl_fire && (rl_slot == SLOT_W'(gi));

            always_comb begin
                count_next = count_reg;
                wptr_next  = wptr_reg;
                rptr_next  = rptr_reg;
                if (st_hit) begin
                    wptr_next = ptr_inc(wptr_reg);
                end
                if (rl_hit) begin
                    rptr_next = ptr_inc(rptr_reg);
                end
                case ({st_hit, rl_hit})
                    2'b10:   count_next = count_reg + 1'b1;
                    2'b01:   count_next = count_reg - 1'b1;
                    default: count_next = count_reg;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    count_reg <= '0;
                    wptr_reg  <= '0;
                    rptr_reg  <= '0;
                end else begin
                    count_reg <= count_next;
                    wptr_reg  <= wptr_next;
                    rptr_reg  <= rptr_next;
                end
            end

            assign cnt_all[gi]  = count_reg;
            assign wptr_all[gi] = wptr_reg;
            assign rptr_all[gi] = rptr_reg;
            assign slot_count[gi*CNT_W +: CNT_W] = count_reg;
        end

        if (ID_WIDTH > IDX_W) begin : g_unused
            logic unused_id_bits;
            assign unused_id_bits = ^r_store_id[ID_WIDTH-1:IDX_W];
        end
    endgenerate

endmodule

// File: tb/tb_r_response_memory.sv
// Directed bench for r_response_memory with 4x4 uid slots, 4-deep buffers and 8-bit ids.
module tb_r_response_memory;

    localparam int ID_W = 8;
    localparam int DW   = 8;
    localparam int CW   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ID_W-1:0] r_store_id = '0;
    logic [DW-1:0]   r_store_data = '0;
    logic [1:0]      r_store_resp = '0;
    logic            r_store_last = 1'b0;
    logic            r_store_valid = 1'b0;
    logic            r_store_ready;
    logic [ID_W-1:0] rm_release_uid = '0;
    logic [ID_W-1:0] r_release_id;
    logic [DW-1:0]   r_release_data;
    logic [1:0]      r_release_resp;
    logic            r_release_last;
    logic            r_release_valid;
    logic            r_release_ready = 1'b0;
    logic [47:0]     slot_count;
    logic            err_release_empty;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    r_response_memory #(
        .ID_WIDTH(ID_W), .MAX_OUTSTANDING(4), .NUM_ROWS(4), .NUM_COLS(4),
        .MAX_LEN(4), .DATA_WIDTH(DW), .RESP_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .r_store_id(r_store_id), .r_store_data(r_store_data), .r_store_resp(r_store_resp),
        .r_store_last(r_store_last), .r_store_valid(r_store_valid), .r_store_ready(r_store_ready),
        .rm_release_uid(rm_release_uid), .r_release_id(r_release_id),
        .r_release_data(r_release_data), .r_release_resp(r_release_resp),
        .r_release_last(r_release_last), .r_release_valid(r_release_valid),
        .r_release_ready(r_release_ready), .slot_count(slot_count),
        .err_release_empty(err_release_empty)
    );

    function automatic logic [2:0] cnt_of(input int s);
        return slot_count[s*CW +: CW];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [7:0] uid, input logic [7:0] data, input logic last);
        r_store_id    = uid;
        r_store_data  = data;
        r_store_resp  = data[1:0];
        r_store_last  = last;
        r_store_valid = 1'b1;
        #1;
        vectors++;
        if (r_store_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL store_ready uid=%h: got %b expected 1", uid, r_store_ready);
        end
        tick;
        r_store_valid = 1'b0;
        $display("store   uid=%h data=%h last=%b", uid, data, last);
    endtask

    task automatic release_expect(input logic [7:0] uid, input logic [7:0] data, input logic last);
        rm_release_uid  = uid;
        r_release_ready = 1'b1;
        #1;
        vectors++;
        if (r_release_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL release_valid uid=%h: got %b expected 1", uid, r_release_valid);
        end
        vectors++;
        if (r_release_data !== data || r_release_resp !== data[1:0] || r_release_last !== last) begin
            miscompares++;
            $display("FAIL release_beat uid=%h: got data=%h resp=%h last=%b expected data=%h resp=%h last=%b",
                     uid, r_release_data, r_release_resp, r_release_last, data, data[1:0], last);
        end
        vectors++;
        if (r_release_id !== uid) begin
            miscompares++;
            $display("FAIL release_id: got %h expected %h", r_release_id, uid);
        end
        tick;
        r_release_ready = 1'b0;
        $display("release uid=%h data=%h last=%b", uid, r_release_data, r_release_last);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
        vectors++;
        if (slot_count !== 48'h0 || err_release_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got counts=%h err=%b expected 0/0", slot_count, err_release_empty);
        end
        for (int u = 0; u < 16; u++) begin
            tick;
            r_store_id     = 8'(u);
            rm_release_uid = 8'(u);
            #1;
            vectors++;
            if (r_store_ready !== 1'b1 || r_release_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_handshake uid=%0d: got ready=%b valid=%b expected 1/0",
                         u, r_store_ready, r_release_valid);
            end
        end
        tick;
    endtask

    task automatic test_store_release;
        store(8'h12, 8'h0A, 1'b0);
        store(8'h12, 8'h0B, 1'b0);
        store(8'h12, 8'h0C, 1'b1);
        vectors++;
        if (cnt_of(2) !== 3'd3) begin
            miscompares++;
            $display("FAIL store3_count: got %0d expected 3", cnt_of(2));
        end
        release_expect(8'h12, 8'h0A, 1'b0);
        release_expect(8'h12, 8'h0B, 1'b0);
        release_expect(8'h12, 8'h0C, 1'b1);
        rm_release_uid = 8'h12;
        #1;
        vectors++;
        if (r_release_valid !== 1'b0 || cnt_of(2) !== 3'd0) begin
            miscompares++;
            $display("FAIL drained_slot: got valid=%b count=%0d expected 0/0", r_release_valid, cnt_of(2));
        end
    endtask

    task automatic test_full;
        for (int i = 0; i < 4; i++) store(8'h05, 8'(8'h50 + i), 1'b0);
        r_store_id    = 8'h05;
        r_store_data  = 8'hEE;
        r_store_resp  = 2'b10;
        r_store_valid = 1'b1;
        #1;
        vectors++;
        if (r_store_ready !== 1'b0 || cnt_of(5) !== 3'd4) begin
            miscompares++;
            $display("FAIL full_ready: got ready=%b count=%0d expected 0/4", r_store_ready, cnt_of(5));
        end
        tick;
        vectors++;
        if (cnt_of(5) !== 3'd4) begin
            miscompares++;
            $display("FAIL full_reject_count: got %0d expected 4", cnt_of(5));
        end
        // release from a full slot while the store keeps trying
        rm_release_uid  = 8'h05;
        r_release_ready = 1'b1;
        #1;
        vectors++;
        if (r_store_ready !== 1'b0 || r_release_valid !== 1'b1 || r_release_data !== 8'h50) begin
            miscompares++;
            $display("FAIL full_simul: got ready=%b valid=%b data=%h expected 0/1/50",
                     r_store_ready, r_release_valid, r_release_data);
        end
        tick;
        r_release_ready = 1'b0;
        r_store_valid   = 1'b0;
        #1;
        vectors++;
        if (cnt_of(5) !== 3'd3 || r_store_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_return: got count=%0d ready=%b expected 3/1", cnt_of(5), r_store_ready);
        end
    endtask

    task automatic test_simultaneous;
        logic [7:0] q[$];
        logic [7:0] d;
        release_expect(8'h05, 8'h51, 1'b0);
        q = '{8'h52, 8'h53};
        for (int i = 0; i < 9; i++) begin
            d = 8'(8'h60 + i);
            r_store_id      = 8'h05;
            r_store_data    = d;
            r_store_resp    = d[1:0];
            r_store_last    = 1'b0;
            r_store_valid   = 1'b1;
            rm_release_uid  = 8'h05;
            r_release_ready = 1'b1;
            #1;
            vectors++;
            if (r_release_valid !== 1'b1 || r_store_ready !== 1'b1 || r_release_data !== q[0]) begin
                miscompares++;
                $display("FAIL simul_beat %0d: got valid=%b ready=%b data=%h expected 1/1/%h",
                         i, r_release_valid, r_store_ready, r_release_data, q[0]);
            end
            tick;
            $display("simul   uid=05 in=%h out=%h", d, q[0]);
            q.push_back(d);
            void'(q.pop_front());
            vectors++;
            if (cnt_of(5) !== 3'd2) begin
                miscompares++;
                $display("FAIL simul_count %0d: got %0d expected 2", i, cnt_of(5));
            end
        end
        r_store_valid   = 1'b0;
        r_release_ready = 1'b0;
        release_expect(8'h05, q[0], 1'b0);
        release_expect(8'h05, q[1], 1'b0);
        vectors++;
        if (cnt_of(5) !== 3'd0) begin
            miscompares++;
            $display("FAIL simul_drain: got %0d expected 0", cnt_of(5));
        end
    endtask

    task automatic test_interleave;
        store(8'h00, 8'h01, 1'b0);
        store(8'h33, 8'h31, 1'b0);
        store(8'h00, 8'h02, 1'b1);
        store(8'h33, 8'h32, 1'b1);
        vectors++;
        if (cnt_of(0) !== 3'd2 || cnt_of(3) !== 3'd2) begin
            miscompares++;
            $display("FAIL interleave_counts: got %0d/%0d expected 2/2", cnt_of(0), cnt_of(3));
        end
        release_expect(8'h33, 8'h31, 1'b0);
        release_expect(8'h33, 8'h32, 1'b1);
        vectors++;
        if (cnt_of(3) !== 3'd0 || cnt_of(0) !== 3'd2) begin
            miscompares++;
            $display("FAIL interleave_mid: got %0d/%0d expected 0/2", cnt_of(3), cnt_of(0));
        end
        release_expect(8'h00, 8'h01, 1'b0);
        release_expect(8'h00, 8'h02, 1'b1);
    endtask

    task automatic test_empty_release;
        logic [47:0] snap;
        store(8'h07, 8'h70, 1'b1);
        snap            = slot_count;
        rm_release_uid  = 8'h21;
        r_release_ready = 1'b1;
        #1;
        vectors++;
        if (r_release_valid !== 1'b0 || err_release_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_pre: got valid=%b err=%b expected 0/0", r_release_valid, err_release_empty);
        end
        tick;
        r_release_ready = 1'b0;
        #1;
        vectors++;
        if (err_release_empty !== 1'b1 || slot_count !== snap) begin
            miscompares++;
            $display("FAIL empty_post: got err=%b counts=%h expected 1/%h", err_release_empty, slot_count, snap);
        end
        repeat (3) tick;
        vectors++;
        if (err_release_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: got %b expected 1", err_release_empty);
        end
    endtask

    task automatic test_mid_reset;
        store(8'h00, 8'h11, 1'b0);
        store(8'h05, 8'h22, 1'b0);
        store(8'h33, 8'h33, 1'b0);
        vectors++;
        if (cnt_of(0) !== 3'd1 || cnt_of(5) !== 3'd1 || cnt_of(3) !== 3'd1 || cnt_of(7) !== 3'd1) begin
            miscompares++;
            $display("FAIL prereset_counts: got %h expected slots 0,3,5,7 at 1", slot_count);
        end
        rst             = 1'b1;
        r_store_id      = 8'h07;
        r_store_data    = 8'h99;
        r_store_valid   = 1'b1;
        rm_release_uid  = 8'h05;
        r_release_ready = 1'b1;
        tick;
        rst             = 1'b0;
        r_store_valid   = 1'b0;
        r_release_ready = 1'b0;
        #1;
        vectors++;
        if (slot_count !== 48'h0 || err_release_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: got counts=%h err=%b expected 0/0", slot_count, err_release_empty);
        end
        for (int u = 0; u < 16; u++) begin
            tick;
            rm_release_uid = 8'(u);
            #1;
            vectors++;
            if (r_release_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_valid uid=%0d: got %b expected 0", u, r_release_valid);
            end
        end
        tick;
    endtask

    task automatic test_upper_bits;
        store(8'hF6, 8'h77, 1'b1);
        vectors++;
        if (cnt_of(6) !== 3'd1) begin
            miscompares++;
            $display("FAIL upper_store: got %0d expected 1", cnt_of(6));
        end
        release_expect(8'h06, 8'h77, 1'b1);
        vectors++;
        if (cnt_of(6) !== 3'd0) begin
            miscompares++;
            $display("FAIL upper_release: got %0d expected 0", cnt_of(6));
        end
    endtask

    initial begin
        test_reset;
        test_store_release;
        test_full;
        test_simultaneous;
        test_interleave;
        test_empty_release;
        test_mid_reset;
        test_upper_bits;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
